// File: rtl/scr1_imem_ahb_pipe.sv
// IMEM-to-AHB-Lite fetch bridge with a configurable request queue, fetch flush and
// optional registered response path (SCR1_IMEM_AHB_PIPE_RESP_REG_EN).
module scr1_imem_ahb_pipe #(
   parameter int unsigned REQ_FIFO_DEPTH = 2,
   parameter int unsigned AHB_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // core instruction memory interface
   output logic                 imem_req_ack,
   input  logic                 imem_req,
   input  logic                 imem_cmd,
   input  logic [AHB_WIDTH-1:0] imem_addr,
   input  logic                 imem_flush,
   output logic [AHB_WIDTH-1:0] imem_rdata,
   output logic [1:0]           imem_resp,
   // AHB-Lite master port
   output logic [3:0]           hprot,
   output logic [2:0]           hburst,
   output logic [2:0]           hsize,
   output logic [1:0]           htrans,
   output logic                 hmastlock,
   output logic [AHB_WIDTH-1:0] haddr,
   input  logic                 hready,
   input  logic [AHB_WIDTH-1:0] hrdata,
   input  logic                 hresp
);

   localparam int unsigned PTR_W = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(REQ_FIFO_DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ_FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_FIFO_DEPTH);

   localparam logic [1:0] MEM_RESP_NOTRDY = 2'b00;
   localparam logic [1:0] MEM_RESP_RDY_OK = 2'b01;
   localparam logic [1:0] MEM_RESP_RDY_ER = 2'b10;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_32B     = 3'b010;
   localparam logic       HRESP_ERROR   = 1'b1;

   localparam logic [0:0] FSM_ADDR = 1'b0;
   localparam logic [0:0] FSM_DATA = 1'b1;

   logic [0:0]           fsm;
   logic [0:0]           fsm_nxt;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     wr_idx;
   logic [CNT_W-1:0]     cnt;
   logic [AHB_WIDTH-1:0] queue_mem [REQ_FIFO_DEPTH];
   logic                 full;
   logic                 empty;
   logic                 wr_en;
   logic                 rd_en;
   logic                 issue_ok;
   logic                 done;
   logic                 discard;
   logic [1:0]           resp_c;
   logic                 unused_cmd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Fetches are read-only; the command carries no information here.
   assign unused_cmd = imem_cmd;

   assign full         = (cnt == CNT_FULL);
   assign empty        = (cnt == '0);
   assign imem_req_ack = ~full;
   assign wr_en        = imem_req & ~full;
   assign issue_ok     = ~empty & ~imem_flush;
   assign done         = (fsm == FSM_DATA) & hready;

   assign hprot     = 4'b0000;
   assign hburst    = HBURST_SINGLE;
   assign hsize     = HSIZE_32B;
   assign hmastlock = 1'b0;
   assign haddr     = queue_mem[rd_ptr];

   // Queue pointers/count; a flush empties the queue but still takes this cycle's write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (imem_flush) begin
         rd_ptr <= '0;
         wr_ptr <= wr_en ? ptr_inc('0) : '0;
         cnt    <= wr_en ? CNT_W'(1) : '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   assign wr_idx = imem_flush ? '0 : wr_ptr;

   // Address storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clk) begin
      if (wr_en) queue_mem[wr_idx] <= imem_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= FSM_ADDR;
      else        fsm <= fsm_nxt;
   end

   // Address-phase control: an ADDR-state issue needs no hready, the bus data phase is idle.
   always_comb begin
      fsm_nxt = fsm;
      htrans  = HTRANS_IDLE;
      rd_en   = 1'b0;
      case (fsm)
         FSM_ADDR: begin
            if (issue_ok) begin
               htrans  = HTRANS_NONSEQ;
               rd_en   = 1'b1;
               fsm_nxt = FSM_DATA;
            end
         end
         FSM_DATA: begin
            if (hready) begin
               if (hresp == HRESP_ERROR) begin
                  fsm_nxt = FSM_ADDR;
               end else if (issue_ok) begin
                  htrans = HTRANS_NONSEQ;
                  rd_en  = 1'b1;
               end else begin
                  fsm_nxt = FSM_ADDR;
               end
            end
         end
         default: fsm_nxt = FSM_ADDR;
      endcase
   end

   // A flush during a stalled data phase squashes that response when it eventually completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             discard <= 1'b0;
      else if (done)                          discard <= 1'b0;
      else if ((fsm == FSM_DATA) & imem_flush) discard <= 1'b1;
   end

   always_comb begin
      resp_c = MEM_RESP_NOTRDY;
      if (done & ~discard & ~imem_flush) begin
         resp_c = (hresp == HRESP_ERROR) ? MEM_RESP_RDY_ER : MEM_RESP_RDY_OK;
      end
   end

`ifdef SCR1_IMEM_AHB_PIPE_RESP_REG_EN
   logic [1:0]           resp_q;
   logic [AHB_WIDTH-1:0] rdata_q;

   // Response register: suppression is already folded into resp_c.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q  <= MEM_RESP_NOTRDY;
         rdata_q <= '0;
      end else begin
         resp_q <= resp_c;
         if (done) rdata_q <= hrdata;
      end
   end

   assign imem_resp  = resp_q;
   assign imem_rdata = rdata_q;
`else
   assign imem_resp  = resp_c;
   assign imem_rdata = hrdata;
`endif

endmodule

// File: tb/tb_scr1_imem_ahb_pipe.sv
// Scoreboard bench for scr1_imem_ahb_pipe (depth 3); works with or without
// SCR1_IMEM_AHB_PIPE_RESP_REG_EN.
module tb_scr1_imem_ahb_pipe;

   localparam int unsigned DEPTH = 3;
`ifdef SCR1_IMEM_AHB_PIPE_RESP_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   localparam logic [1:0] R_NOTRDY  = 2'b00;
   localparam logic [1:0] R_OK      = 2'b01;
   localparam logic [1:0] R_ER      = 2'b10;
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req_ack;
   logic        imem_req;
   logic        imem_cmd;
   logic [31:0] imem_addr;
   logic        imem_flush;
   logic [31:0] imem_rdata;
   logic [1:0]  imem_resp;
   logic [3:0]  hprot;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [31:0] haddr;
   logic        hready;
   logic [31:0] hrdata;
   logic        hresp;

   always #5 clk = ~clk;

   scr1_imem_ahb_pipe #(.REQ_FIFO_DEPTH(DEPTH), .AHB_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_ack(imem_req_ack), .imem_req(imem_req), .imem_cmd(imem_cmd),
      .imem_addr(imem_addr), .imem_flush(imem_flush),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .hprot(hprot), .hburst(hburst), .hsize(hsize), .htrans(htrans),
      .hmastlock(hmastlock), .haddr(haddr),
      .hready(hready), .hrdata(hrdata), .hresp(hresp)
   );

   typedef struct {
      int          due;
      logic [1:0]  resp;
      logic [31:0] data;
   } resp_t;

   resp_t       rq[$];
   logic [31:0] aq[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic        dphase    = 1'b0;
   logic        discard_m = 1'b0;
   logic [31:0] dp_addr     = 32'h0;
   logic [31:0] dp_addr_nxt = 32'h0;

   // Slave data: a fixed scramble of the address of the transfer in its data phase.
   assign hrdata = dp_addr ^ 32'h5A5A_0000;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      dp_addr <= dp_addr_nxt;
   end

   // Scoreboard: addresses queued on acceptance, responses queued on data-phase completion.
   always @(negedge clk) begin
      resp_t e;
      logic  comp;
      if (!rst_n) begin
         rq.delete();
         aq.delete();
         dphase    = 1'b0;
         discard_m = 1'b0;
      end else begin
         if (htrans == HT_NONSEQ) begin
            if (aq.size() == 0) chk("nonseq_unexp", 32'(htrans), 32'(HT_IDLE));
            else begin
               chk("haddr", haddr, aq.pop_front());
               dp_addr_nxt = haddr;
            end
         end
         if (imem_flush) chk("flush_htrans", 32'(htrans), 32'(HT_IDLE));
         comp = dphase & hready;
         if (comp && !imem_flush && !discard_m) begin
            e.due  = cyc + LAT;
            e.resp = hresp ? R_ER : R_OK;
            e.data = hrdata;
            rq.push_back(e);
         end
         if (comp)                     discard_m = 1'b0;
         else if (dphase && imem_flush) discard_m = 1'b1;
         if (htrans == HT_NONSEQ) dphase = 1'b1;
         else if (comp)           dphase = 1'b0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            chk("imem_resp", 32'(imem_resp), 32'(e.resp));
            chk("imem_rdata", imem_rdata, e.data);
         end else begin
            chk("resp_idle", 32'(imem_resp), 32'(R_NOTRDY));
         end
         if (imem_flush) aq.delete();
         if (imem_req && imem_req_ack) aq.push_back(imem_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic req, input logic [31:0] addr, input logic flush,
                      input logic rdy, input logic rsp);
      imem_req   = req;
      imem_addr  = addr;
      imem_flush = flush;
      hready     = rdy;
      hresp      = rsp;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         tick();
      end
   endtask

   initial begin
      int   acc_n;
      logic acc;
      imem_req = 1'b0; imem_addr = 32'h0; imem_cmd = 1'b0;
      imem_flush = 1'b0; hready = 1'b1; hresp = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(imem_req_ack), 32'd1);
      chk("rst_htrans", 32'(htrans), 32'(HT_IDLE));
      chk("rst_resp", 32'(imem_resp), 32'(R_NOTRDY));
      chk("hprot", 32'(hprot), 32'd0);
      chk("hburst", 32'(hburst), 32'd0);
      chk("hsize", 32'(hsize), 32'd2);
      chk("hmastlock", 32'(hmastlock), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // back-to-back fetches with hready high
      for (int c = 0; c < 8; c++) begin
         drv(c < 4, 32'h100 + 32'(4 * c), 1'b0, 1'b1, 1'b0);
         if (c < 4) chk("t1_ack", 32'(imem_req_ack), 32'd1);
         if (c >= 1 && c <= 4) chk("t1_b2b", 32'(htrans), 32'(HT_NONSEQ));
         tick();
      end

      // stalled slave fills the queue, then drains with pointer wrap
      acc_n = 0;
      for (int c = 0; c < 14; c++) begin
         drv(acc_n < 5, 32'h400 + 32'(4 * acc_n), 1'b0, !(c >= 2 && c <= 5), 1'b0);
         if (c == 4 || c == 5) chk("t2_ack_full", 32'(imem_req_ack), 32'd0);
         acc = imem_req & imem_req_ack;
         tick();
         if (acc) acc_n++;
      end
      chk("t2_accepted", 32'(acc_n), 32'd5);

      // two-cycle ERROR on the second transfer
      drv(1'b1, 32'h500, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h504, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h508, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("t3_stall_idle", 32'(htrans), 32'(HT_IDLE)); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("t3_err_idle", 32'(htrans), 32'(HT_IDLE)); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t3_next_issue", 32'(htrans), 32'(HT_NONSEQ));
      chk("t3_next_addr", haddr, 32'h508); tick();
      idle(3);

      // flush during a stalled data phase with two entries queued
      drv(1'b1, 32'h600, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h604, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h608, 1'b0, 1'b0, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_flush_idle", 32'(htrans), 32'(HT_IDLE)); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t4_stall_idle", 32'(htrans), 32'(HT_IDLE)); tick();
      for (int c = 0; c < 4; c++) begin
         drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         chk("t4_no_issue", 32'(htrans), 32'(HT_IDLE));
         chk("t4_resp", 32'(imem_resp), 32'(R_NOTRDY));
         chk("t4_ack", 32'(imem_req_ack), 32'd1);
         tick();
      end

      // flush and a new request in the same cycle, completing transfer squashed
      drv(1'b1, 32'h700, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h704, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
      chk("t5_flush_idle", 32'(htrans), 32'(HT_IDLE));
      chk("t5_flush_resp", 32'(imem_resp), 32'(R_NOTRDY)); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t5_issue", 32'(htrans), 32'(HT_NONSEQ));
      chk("t5_addr", haddr, 32'h200); tick();
      idle(3);
      chk("sb_resp_drain", 32'(rq.size()), 32'd0);
      chk("sb_addr_drain", 32'(aq.size()), 32'd0);

      // asynchronous reset in the middle of a stalled transfer, then recovery
      drv(1'b1, 32'h800, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b1, 32'h804, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ack", 32'(imem_req_ack), 32'd1);
      chk("t6_rst_htrans", 32'(htrans), 32'(HT_IDLE));
      chk("t6_rst_resp", 32'(imem_resp), 32'(R_NOTRDY));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      drv(1'b1, 32'h900, 1'b0, 1'b1, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t6_issue", 32'(htrans), 32'(HT_NONSEQ));
      chk("t6_addr", haddr, 32'h900); tick();
      idle(3);
      chk("sb_resp_drain2", 32'(rq.size()), 32'd0);
      chk("sb_addr_drain2", 32'(aq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
